lcm_initiator: RTL and testbench

//  Host-side initiator for LCM register access. Turns one request (read/write, reg number, value) into a
//  2-word 134-bit control packet toward the DMUX->LCM path. For reads, it waits for the LCM reply packet on
//  the MUX return path, extracts the 64-bit value, and returns it or flags a timeout.

---
 rtl/lcm_pkt_pkg.sv | 59 +++++
 rtl/lcm_initiator_if.sv | 42 ++++
 rtl/lcm_rsp_parser.sv | 61 ++++++
 rtl/lcm_initiator.sv | 179 +++++++++++++++++
 tb/tb_lcm_initiator.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/lcm_pkt_pkg.sv
// Packet definitions shared by the LCM initiator and the LCM-side parser.
// A packet is two 134-bit words: {flag[1:0], vbytes[3:0], data[127:0]}.
//   head data: [127:120]dst [119:112]src [111:104]opcode [103:96]reg [95:88]seq, rest 0
//   tail data: [127:64]value, [63:0]=0
package lcm_pkt_pkg;

  typedef struct packed {
    logic [1:0]   flag;
    logic [3:0]   vbytes;
    logic [127:0] data;
  } word_t;

  typedef struct packed {
    logic [7:0] dst;
    logic [7:0] src;
    logic [7:0] op;
    logic [7:0] rg;
    logic [7:0] seq;
  } hdr_t;

  localparam logic [1:0] FLAG_HEAD  = 2'b01;
  localparam logic [1:0] FLAG_TAIL  = 2'b10;
  localparam logic [3:0] VBYTES_ALL = 4'hF;

  localparam logic [7:0] OP_WR     = 8'h01;
  localparam logic [7:0] OP_RD     = 8'h02;
  localparam logic [7:0] OP_RD_RSP = 8'h03;

  // Field positions inside word_t.data
  localparam int HDR_LSB = 88;
  localparam int VAL_LSB = 64;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_HDR, S_SEND_TAIL, S_WAIT_RSP, S_DONE
  } state_t;

  function automatic word_t build_head(input hdr_t h);
    word_t w;
    w = '0;
    w.flag = FLAG_HEAD;
    w.vbytes = VBYTES_ALL;
    w.data[HDR_LSB +: 40] = h;
    return w;
  endfunction

  function automatic word_t build_tail(input logic [63:0] v);
    word_t w;
    w = '0;
    w.flag = FLAG_TAIL;
    w.vbytes = VBYTES_ALL;
    w.data[VAL_LSB +: 64] = v;
    return w;
  endfunction

  function automatic hdr_t parse_head(input logic [39:0] hdr_bits);
    return hdr_t'(hdr_bits);
  endfunction

endpackage

// File: rtl/lcm_initiator_if.sv
// Bus bundle of the LCM initiator: CPU request/response port, command packet
// output toward DMUX->LCM, and reply packet input from the MUX return path.
//   master: the initiator side (drives req_ready, rsp_*, out_cmd_*)
//   slave : the host/pipeline side
interface lcm_initiator_if;
  import lcm_pkt_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [7:0]  req_reg;
  logic [63:0] req_wdata;

  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  word_t       out_cmd_data;
  logic        out_cmd_data_wr;
  logic        out_cmd_data_valid;
  logic        out_cmd_data_valid_wr;
  logic        out_cmd_data_ready;

  word_t       in_rsp_data;
  logic        in_rsp_data_wr;
  logic        in_rsp_data_valid;
  logic        in_rsp_data_valid_wr;

  modport master (
    input  req_valid, req_wr, req_reg, req_wdata, out_cmd_data_ready,
           in_rsp_data, in_rsp_data_wr, in_rsp_data_valid, in_rsp_data_valid_wr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           out_cmd_data, out_cmd_data_wr, out_cmd_data_valid, out_cmd_data_valid_wr
  );

  modport slave (
    output req_valid, req_wr, req_reg, req_wdata, out_cmd_data_ready,
           in_rsp_data, in_rsp_data_wr, in_rsp_data_valid, in_rsp_data_valid_wr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           out_cmd_data, out_cmd_data_wr, out_cmd_data_valid, out_cmd_data_valid_wr
  );
endinterface

// File: rtl/lcm_rsp_parser.sv
// Reply capture for the LCM initiator. Watches the return word stream and
// pulses match_o on the tail of a read reply whose head carried
// {dst=SRC_ID, src=LMID, opcode=RD_RSP, reg=exp_reg_i, seq=exp_seq_i}.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   en_i           capture enabled (initiator waiting for a reply)
//   exp_reg_i/_seq_i  expected reg number / sequence
//   data_i, wr_i   reply word and strobe
//   valid_i, valid_wr_i  packet valid and its strobe
//   match_o        combinational: this cycle's tail completes a match
//   value_o        tail value, meaningful with match_o
module lcm_rsp_parser
  import lcm_pkt_pkg::*;
#(
  parameter logic [7:0] LMID   = 8'd3,
  parameter logic [7:0] SRC_ID = 8'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [7:0]  exp_reg_i,
  input  logic [7:0]  exp_seq_i,
  input  word_t       data_i,
  input  logic        wr_i,
  input  logic        valid_i,
  input  logic        valid_wr_i,
  output logic        match_o,
  output logic [63:0] value_o
);

  hdr_t h;
  logic head_ok, is_head, is_tail, discard;
  logic hdr_ok_q, hdr_ok_d;

  logic unused_bits;
  assign unused_bits = ^{data_i.vbytes, data_i.data[VAL_LSB-1:0]};

  assign h       = parse_head(data_i.data[HDR_LSB +: 40]);
  assign is_head = wr_i && (data_i.flag == FLAG_HEAD);
  assign is_tail = wr_i && (data_i.flag == FLAG_TAIL);
  // Packet explicitly marked invalid: drop whatever has been captured.
  assign discard = valid_wr_i && !valid_i;
  assign head_ok = (h.dst == SRC_ID) && (h.src == LMID) && (h.op == OP_RD_RSP) &&
                   (h.rg == exp_reg_i) && (h.seq == exp_seq_i);

  always_comb begin
    hdr_ok_d = hdr_ok_q;
    if (!en_i || discard)  hdr_ok_d = 1'b0;
    else if (is_head)      hdr_ok_d = head_ok;   // a new head restarts capture
    else if (is_tail)      hdr_ok_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hdr_ok_q <= 1'b0;
    else        hdr_ok_q <= hdr_ok_d;
  end

  assign match_o = en_i && hdr_ok_q && is_tail && !discard;
  assign value_o = data_i.data[VAL_LSB +: 64];

endmodule

// File: rtl/lcm_initiator.sv
// Host-side initiator for LCM register access. Accepts one read/write request,
// emits a head+tail command packet, and for reads waits for the matching reply
// (or a timeout) before pulsing rsp_valid.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus          lcm_initiator_if.master: req_*, rsp_*, out_cmd_*, in_rsp_*
// All bus outputs are registered and clear on reset.
module lcm_initiator
  import lcm_pkt_pkg::*;
#(
  parameter logic [7:0]  LMID    = 8'd3,
  parameter logic [7:0]  SRC_ID  = 8'd0,
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  logic             clk,
  input  logic             rst_n,
  lcm_initiator_if.master  bus
);

  state_t      state_q, state_d;
  logic [7:0]  seq_q, seq_d;
  logic [15:0] cnt_q, cnt_d;
  logic        lat_wr_q, lat_wr_d;
  logic [7:0]  lat_reg_q, lat_reg_d;
  logic [63:0] lat_wdata_q, lat_wdata_d;
  logic [63:0] res_data_q, res_data_d;
  logic        res_err_q, res_err_d;
  logic        req_ready_q, req_ready_d;
  word_t       cmd_data_q, cmd_data_d;
  logic        cmd_wr_q, cmd_wr_d;
  logic        cmd_tail_q, cmd_tail_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        match;
  logic [63:0] match_val;
  hdr_t        hdr;

  lcm_rsp_parser #(.LMID(LMID), .SRC_ID(SRC_ID)) u_parser (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (state_q == S_WAIT_RSP),
    .exp_reg_i  (lat_reg_q),
    .exp_seq_i  (seq_q),
    .data_i     (bus.in_rsp_data),
    .wr_i       (bus.in_rsp_data_wr),
    .valid_i    (bus.in_rsp_data_valid),
    .valid_wr_i (bus.in_rsp_data_valid_wr),
    .match_o    (match),
    .value_o    (match_val)
  );

  always_comb begin
    hdr.dst = LMID;
    hdr.src = SRC_ID;
    hdr.op  = lat_wr_q ? OP_WR : OP_RD;
    hdr.rg  = lat_reg_q;
    hdr.seq = seq_q;
  end

  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    cnt_d       = cnt_q;
    lat_wr_d    = lat_wr_q;
    lat_reg_d   = lat_reg_q;
    lat_wdata_d = lat_wdata_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    cmd_data_d  = cmd_data_q;   // last word stays on the bus; wr qualifies it
    cmd_wr_d    = 1'b0;
    cmd_tail_d  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          lat_wr_d    = bus.req_wr;
          lat_reg_d   = bus.req_reg;
          lat_wdata_d = bus.req_wdata;
          state_d     = S_SEND_HDR;
        end
      end
      S_SEND_HDR: begin
        if (bus.out_cmd_data_ready) begin
          cmd_data_d = build_head(hdr);
          cmd_wr_d   = 1'b1;
          state_d    = S_SEND_TAIL;
        end
      end
      S_SEND_TAIL: begin
        if (bus.out_cmd_data_ready) begin
          cmd_data_d = build_tail(lat_wr_q ? lat_wdata_q : 64'h0);
          cmd_wr_d   = 1'b1;
          cmd_tail_d = 1'b1;
          cnt_d      = '0;
          res_data_d = '0;
          res_err_d  = 1'b0;
          state_d    = lat_wr_q ? S_DONE : S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        cnt_d = cnt_q + 16'd1;
        // Leave on the edge where the counter reaches TIMEOUT-1, so the
        // response lands exactly TIMEOUT cycles after the tail.
        // A match in that same cycle takes priority.
        if (match) begin
          res_data_d = match_val;
          res_err_d  = 1'b0;
          state_d    = S_DONE;
        end else if (cnt_q == TIMEOUT - 16'd2) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = res_data_q;
        rsp_err_d   = res_err_q;
        seq_d       = seq_q + 8'd1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered so it reads 0 while in reset like every other output.
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      seq_q       <= '0;
      cnt_q       <= '0;
      lat_wr_q    <= 1'b0;
      lat_reg_q   <= '0;
      lat_wdata_q <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      req_ready_q <= 1'b0;
      cmd_data_q  <= '0;
      cmd_wr_q    <= 1'b0;
      cmd_tail_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      cnt_q       <= cnt_d;
      lat_wr_q    <= lat_wr_d;
      lat_reg_q   <= lat_reg_d;
      lat_wdata_q <= lat_wdata_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      req_ready_q <= req_ready_d;
      cmd_data_q  <= cmd_data_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_tail_q  <= cmd_tail_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready             = req_ready_q;
  assign bus.rsp_valid             = rsp_valid_q;
  assign bus.rsp_rdata             = rsp_rdata_q;
  assign bus.rsp_err               = rsp_err_q;
  assign bus.out_cmd_data          = cmd_data_q;
  assign bus.out_cmd_data_wr       = cmd_wr_q;
  assign bus.out_cmd_data_valid    = cmd_tail_q;
  assign bus.out_cmd_data_valid_wr = cmd_tail_q;

endmodule

// File: tb/tb_lcm_initiator.sv
// Directed bench for lcm_initiator (TIMEOUT=16). Command words and responses
// are predicted into queues when stimulus is driven and compared by monitors
// when the DUT emits them; timing checks live in the main sequence.
module tb_lcm_initiator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] tb_seq = 8'd0;

  typedef struct packed { logic [63:0] rdata; logic err; } rsp_t;
  logic [133:0] cmd_q[$];
  rsp_t         rsp_q[$];

  always #5 clk = ~clk;

  lcm_initiator_if bus();

  lcm_initiator #(.LMID(8'd3), .SRC_ID(8'd0), .TIMEOUT(16'd16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [133:0] mk_head(input logic [7:0] dst, src, op, rg, sq);
    return {2'b01, 4'hF, dst, src, op, rg, sq, 88'h0};
  endfunction

  function automatic logic [133:0] mk_tail(input logic [63:0] v);
    return {2'b10, 4'hF, v, 64'h0};
  endfunction

  task automatic chkw(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (rst_n && bus.out_cmd_data_wr) begin
      if (cmd_q.size() == 0) chkn("cmd_unexpected", cmd_q.size(), 1);
      else begin
        logic [133:0] e;
        e = cmd_q.pop_front();
        chkw("cmd_word", bus.out_cmd_data, e);
        chk1("cmd_valid", bus.out_cmd_data_valid, e[133:132] == 2'b10);
        chk1("cmd_valid_wr", bus.out_cmd_data_valid_wr, e[133:132] == 2'b10);
      end
    end
    if (rst_n && bus.rsp_valid) begin
      if (rsp_q.size() == 0) chkn("rsp_unexpected", rsp_q.size(), 1);
      else begin
        rsp_t r;
        r = rsp_q.pop_front();
        chkw("rsp_rdata", {70'h0, bus.rsp_rdata}, {70'h0, r.rdata});
        chk1("rsp_err", bus.rsp_err, r.err);
      end
    end
  end

  task automatic send_req(input logic wr, input logic [7:0] rg, input logic [63:0] wd);
    int n;
    n = 0;
    tick();
    while (!bus.req_ready && n < 50) begin tick(); n++; end
    chk1("req_ready", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_reg   = rg;
    bus.req_wdata = wd;
    cmd_q.push_back(mk_head(8'd3, 8'd0, wr ? 8'h01 : 8'h02, rg, tb_seq));
    cmd_q.push_back(mk_tail(wr ? wd : 64'h0));
    if (wr) rsp_q.push_back({64'h0, 1'b0});
    tb_seq = tb_seq + 8'd1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_tail();
    int n;
    n = 0;
    do begin tick(); n++; end while (!bus.out_cmd_data_valid_wr && n < 20);
    chk1("tail_seen", bus.out_cmd_data_valid_wr, 1'b1);
  endtask

  task automatic send_reply(input logic [7:0] rg, sq, input logic [63:0] v, input logic vld);
    tick();
    bus.in_rsp_data    = mk_head(8'd0, 8'd3, 8'h03, rg, sq);
    bus.in_rsp_data_wr = 1'b1;
    tick();
    bus.in_rsp_data          = mk_tail(v);
    bus.in_rsp_data_valid    = vld;
    bus.in_rsp_data_valid_wr = 1'b1;
    tick();
    bus.in_rsp_data          = '0;
    bus.in_rsp_data_wr       = 1'b0;
    bus.in_rsp_data_valid    = 1'b0;
    bus.in_rsp_data_valid_wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    int n;
    bus.req_valid = 0; bus.req_wr = 0; bus.req_reg = 0; bus.req_wdata = 0;
    bus.out_cmd_data_ready = 1;
    bus.in_rsp_data = '0; bus.in_rsp_data_wr = 0;
    bus.in_rsp_data_valid = 0; bus.in_rsp_data_valid_wr = 0;

    // Reset state
    repeat (3) tick();
    chk1("rst_req_ready", bus.req_ready, 1'b0);
    chk1("rst_cmd_wr", bus.out_cmd_data_wr, 1'b0);
    chk1("rst_cmd_valid", bus.out_cmd_data_valid, 1'b0);
    chk1("rst_cmd_valid_wr", bus.out_cmd_data_valid_wr, 1'b0);
    chkw("rst_cmd_data", bus.out_cmd_data, 134'h0);
    chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("rst_rsp_err", bus.rsp_err, 1'b0);
    chkw("rst_rsp_rdata", {70'h0, bus.rsp_rdata}, 134'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: write latency, head T+1, tail T+2, rsp T+3
    send_req(1'b1, 8'h05, 64'hDEAD_BEEF);
    tick(); chk1("t1_no_wr_at_T", bus.out_cmd_data_wr, 1'b0);
    tick(); chk1("t1_head_wr", bus.out_cmd_data_wr, 1'b1);
            chk1("t1_head_not_tail", bus.out_cmd_data_valid_wr, 1'b0);
    tick(); chk1("t1_tail_wr", bus.out_cmd_data_wr, 1'b1);
            chk1("t1_tail_valid_wr", bus.out_cmd_data_valid_wr, 1'b1);
    tick(); chk1("t1_rsp_valid", bus.rsp_valid, 1'b1);
    tick(); chk1("t1_rsp_pulse", bus.rsp_valid, 1'b0);

    // 2: read, reply 8 cycles after tail (inside the 16-cycle timeout)
    s = tb_seq;
    send_req(1'b0, 8'h10, 64'h0);
    wait_tail();
    repeat (8) tick();
    rsp_q.push_back({64'h1234, 1'b0});
    send_reply(8'h10, s, 64'h1234, 1'b1);
    tick(); chk1("t2_rsp_valid", bus.rsp_valid, 1'b1);

    // 3: downstream stall on the head word
    bus.out_cmd_data_ready = 1'b0;
    send_req(1'b1, 8'h22, 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 5; i++) begin
      tick(); chk1("t3_stall_no_wr", bus.out_cmd_data_wr, 1'b0);
    end
    bus.out_cmd_data_ready = 1'b1;
    tick(); chk1("t3_head_after_release", bus.out_cmd_data_wr, 1'b1);
            chk1("t3_head_not_tail", bus.out_cmd_data_valid_wr, 1'b0);
    tick(); chk1("t3_tail_next", bus.out_cmd_data_valid_wr, 1'b1);
    tick(); chk1("t3_rsp_valid", bus.rsp_valid, 1'b1);

    // 4: read timeout, rsp exactly 16 cycles after the tail
    send_req(1'b0, 8'h44, 64'h0);
    rsp_q.push_back({64'h0, 1'b1});
    wait_tail();
    n = 0;
    do begin tick(); n++; end while (!bus.rsp_valid && n < 40);
    chkn("t4_timeout_latency", n, 16);

    // 5: wrong seq and invalidated replies dropped, correct one returned
    s = tb_seq;
    send_req(1'b0, 8'h55, 64'h0);
    wait_tail();
    send_reply(8'h55, s + 8'd1, 64'hBAD, 1'b1);
    tick(); chk1("t5_wrong_seq_dropped", bus.rsp_valid, 1'b0);
    send_reply(8'h55, s, 64'hBAD2, 1'b0);
    tick(); chk1("t5_invalid_dropped", bus.rsp_valid, 1'b0);
    rsp_q.push_back({64'h5555_AAAA_0000_1111, 1'b0});
    send_reply(8'h55, s, 64'h5555_AAAA_0000_1111, 1'b1);
    tick(); chk1("t5_rsp_valid", bus.rsp_valid, 1'b1);
    repeat (2) tick();
    send_reply(8'h55, tb_seq, 64'h9, 1'b1);   // arrives while idle
    for (int i = 0; i < 3; i++) begin
      tick(); chk1("t5_idle_reply_no_rsp", bus.rsp_valid, 1'b0);
    end

    // 6: async reset between head and tail
    send_req(1'b1, 8'h66, 64'hCAFE);
    tick(); tick();
    chk1("t6_head_wr", bus.out_cmd_data_wr, 1'b1);
    #2 rst_n = 1'b0;
    cmd_q.delete();
    rsp_q.delete();
    tb_seq = 8'd0;
    #1;
    chk1("t6_rst_cmd_wr", bus.out_cmd_data_wr, 1'b0);
    chkw("t6_rst_cmd_data", bus.out_cmd_data, 134'h0);
    chk1("t6_rst_req_ready", bus.req_ready, 1'b0);
    chk1("t6_rst_valid_wr", bus.out_cmd_data_valid_wr, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk1("t6_no_tail_after_rst", bus.out_cmd_data_wr, 1'b0);
      chk1("t6_no_rsp_after_rst", bus.rsp_valid, 1'b0);
    end
    send_req(1'b1, 8'h07, 64'h77);   // expects seq 0 in its head
    repeat (6) tick();

    chkn("end_cmd_queue_drained", cmd_q.size(), 0);
    chkn("end_rsp_queue_drained", rsp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
